// File: rtl/encoder_pkg.sv
// Shared types for the tokenizer encoder scheduler.
// UNK_ID is used only when ENCODER_SCHED_UNK_EN is defined.
package encoder_pkg;

  localparam int TOKEN_W = 8;

  typedef logic [TOKEN_W-1:0] token_id_t;

  localparam token_id_t UNK_ID = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_EVAL,
    S_EMIT,
    S_FINISH
  } enc_sched_state_e;

endpackage

// File: rtl/encoder_best_match.sv
// Best-candidate register for one input position.
// A candidate replaces the held entry only when strictly longer.
module encoder_best_match #(
  parameter int LW = 5,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cand,
  input  logic [LW-1:0] len,
  input  logic [IW-1:0] id,
  output logic [LW-1:0] best_len,
  output logic [IW-1:0] best_id
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_len <= '0;
      best_id  <= '0;
    end else if (clr) begin
      best_len <= '0;
      best_id  <= '0;
    end else if (cand && (len > best_len)) begin
      best_len <= len;
      best_id  <= id;
    end
  end

endmodule

// File: rtl/encoder_sched.sv
// Encoder scheduler: longest-match token selection per input position.
// Define ENCODER_SCHED_UNK_EN to emit UNK_ID for unmatched bytes.
module encoder_sched
  import encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int VOCAB_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   in_len,
  output logic                  m_start,
  output logic [ADDR_WIDTH-1:0] m_ai,
  output logic [ADDR_WIDTH-1:0] m_av,
  input  logic                  m_done,
  input  logic                  m_found,
  input  logic [ADDR_WIDTH:0]   m_len,
  output logic [ADDR_WIDTH-1:0] ao,
  output logic                  w,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [ADDR_WIDTH:0]   ntok
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int SW = ADDR_WIDTH + 2;

  enc_sched_state_e state, state_nx;

  logic [LW-1:0]         ptr;
  logic [ADDR_WIDTH-1:0] vidx;
  logic [ADDR_WIDTH-1:0] ao_q;
  logic [LW-1:0]         ntok_q;
  logic                  ovf_q;
  logic [LW-1:0]         best_len;
  logic [DATA_WIDTH-1:0] best_id;
  logic [DATA_WIDTH-1:0] tok;
  logic [LW-1:0]         adv;
  logic [SW-1:0]         fit_sum;
  logic [SW-1:0]         ptr_nx;
  logic                  run;
  logic                  cand;
  logic                  clr_best;
  logic                  has_best;
  logic                  last_v;
  logic                  wr_tok;

  assign run = (state == S_SCAN) || (state == S_WAIT) ||
               (state == S_EVAL) || (state == S_EMIT);

  // Sums are one bit wider than in_len so they never wrap
  assign fit_sum  = SW'(ptr) + SW'(m_len);
  assign cand     = (state == S_WAIT) && m_done && m_found &&
                    (m_len != '0) && (fit_sum <= SW'(in_len));
  assign last_v   = (vidx == ADDR_WIDTH'(VOCAB_SIZE - 1));
  assign has_best = (best_len != '0);
  assign adv      = has_best ? best_len : LW'(1);
  assign ptr_nx   = SW'(ptr) + SW'(adv);
  assign clr_best = (state == S_IDLE) || (state == S_EMIT);

`ifdef ENCODER_SCHED_UNK_EN
  assign wr_tok = 1'b1;
  assign tok    = has_best ? best_id : DATA_WIDTH'(UNK_ID);
`else
  assign wr_tok = has_best;
  assign tok    = best_id;
`endif

  encoder_best_match #(
    .LW(LW),
    .IW(DATA_WIDTH)
  ) u_best (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_best),
    .cand    (cand),
    .len     (m_len),
    .id      (DATA_WIDTH'(vidx)),
    .best_len(best_len),
    .best_id (best_id)
  );

  assign m_ai  = ptr[ADDR_WIDTH-1:0];
  assign m_av  = vidx;
  assign ao    = ao_q;
  assign ntok  = ntok_q;
  assign ovf   = ovf_q;
  assign wdata = w ? tok : '0;

  always_comb begin
    state_nx = state;
    m_start  = 1'b0;
    w        = 1'b0;
    busy     = run;
    done     = (state == S_FINISH);
    unique case (state)
      S_IDLE: begin
        if (cs) state_nx = (in_len == '0) ? S_FINISH : S_SCAN;
      end
      S_SCAN: begin
        m_start  = cs;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) state_nx = S_EVAL;
      end
      S_EVAL: begin
        state_nx = last_v ? S_EMIT : S_SCAN;
      end
      S_EMIT: begin
        w = cs && wr_tok;
        if (ptr_nx >= SW'(in_len)) state_nx = S_FINISH;
        else if (wr_tok && (ao_q == '1)) state_nx = S_FINISH;
        else state_nx = S_SCAN;
      end
      S_FINISH: begin
        if (!cs) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (run && !cs) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      vidx   <= '0;
      ao_q   <= '0;
      ntok_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && cs) begin
        ptr    <= '0;
        vidx   <= '0;
        ao_q   <= '0;
        ntok_q <= '0;
        ovf_q  <= 1'b0;
      end
      if ((state == S_EVAL) && cs && !last_v) begin
        vidx <= vidx + 1'b1;
      end
      if ((state == S_EMIT) && cs) begin
        vidx <= '0;
        ptr  <= ptr_nx[LW-1:0];
        if (wr_tok) begin
          ao_q   <= ao_q + 1'b1;
          ntok_q <= ntok_q + 1'b1;
          if ((ptr_nx < SW'(in_len)) && (ao_q == '1)) ovf_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_sched.sv
// Scoreboard bench for encoder_sched with a behavioural matcher model.
// Expectations follow ENCODER_SCHED_UNK_EN when it is defined.
module tb_encoder_sched;

  localparam int AW  = 4;
  localparam int LW  = 5;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          cs;
  logic [LW-1:0] in_len;
  logic          m_start;
  logic [AW-1:0] m_ai;
  logic [AW-1:0] m_av;
  logic          m_done;
  logic          m_found;
  logic [LW-1:0] m_len;
  logic [AW-1:0] ao;
  logic          w;
  logic [7:0]    wdata;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [LW-1:0] ntok;

  logic       cs2;
  logic [2:0] in_len2;
  logic       m_start2;
  logic [1:0] m_ai2;
  logic [1:0] m_av2;
  logic       m_done2;
  logic       m_found2;
  logic [2:0] m_len2;
  logic [1:0] ao2;
  logic       w2;
  logic [7:0] wdata2;
  logic       busy2;
  logic       done2;
  logic       ovf2;
  logic [2:0] ntok2;

  encoder_sched #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(8),
    .VOCAB_SIZE(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_len(in_len),
    .m_start(m_start), .m_ai(m_ai), .m_av(m_av),
    .m_done(m_done), .m_found(m_found), .m_len(m_len),
    .ao(ao), .w(w), .wdata(wdata), .busy(busy),
    .done(done), .ovf(ovf), .ntok(ntok)
  );

  encoder_sched #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(8),
    .VOCAB_SIZE(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .cs(cs2), .in_len(in_len2),
    .m_start(m_start2), .m_ai(m_ai2), .m_av(m_av2),
    .m_done(m_done2), .m_found(m_found2), .m_len(m_len2),
    .ao(ao2), .w(w2), .wdata(wdata2), .busy(busy2),
    .done(done2), .ovf(ovf2), .ntok(ntok2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  n_chk;
  int  n_fail;
  int  m_starts;

  logic [7:0] ibuf[16];
  logic [7:0] vb[16][4];
  int         vl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push1(input int a, input int d);
    wr_t e;
    e.a = a;
    e.d = d;
    q1.push_back(e);
  endtask

  // Write monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin : mon
    wr_t e;
    if (m_start === 1'b1) m_starts++;
    if (w === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexp: ao=%0d wdata=%0d", ao, wdata);
      end else begin
        e = q1.pop_front();
        chk("wr_ao", 32'(ao), e.a);
        chk("wr_data", 32'(wdata), e.d);
      end
    end
    if (w2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr2_unexp: ao=%0d wdata=%0d", ao2, wdata2);
      end else begin
        e = q2.pop_front();
        chk("wr2_ao", 32'(ao2), e.a);
        chk("wr2_data", 32'(wdata2), e.d);
      end
    end
  end

  // Matcher model, LAT cycles from start to done
  int ma;
  int mv;
  bit mok;
  always begin
    @(negedge clk);
    if (m_start === 1'b1) begin
      ma = int'(m_ai);
      mv = int'(m_av);
      repeat (LAT - 1) @(negedge clk);
      mok = (vl[mv] > 0);
      for (int k = 0; k < 4; k++) begin
        if (k < vl[mv]) begin
          if (ma + k > 15) mok = 1'b0;
          else if (ibuf[ma+k] !== vb[mv][k]) mok = 1'b0;
        end
      end
      m_done  = 1'b1;
      m_found = mok;
      m_len   = mok ? LW'(vl[mv]) : '0;
      @(negedge clk);
      m_done  = 1'b0;
      m_found = 1'b0;
      m_len   = '0;
    end
  end

  // Second instance: every lookup matches one byte
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_done2 <= 1'b0;
    else m_done2 <= m_start2;
  end
  assign m_found2 = 1'b1;
  assign m_len2   = 3'd1;

  task automatic clr_vocab();
    for (int i = 0; i < 16; i++) vl[i] = 0;
  endtask

  task automatic set_v(input int i, input string s);
    vl[i] = s.len();
    for (int k = 0; k < s.len(); k++) vb[i][k] = s[k];
  endtask

  task automatic set_in(input string s);
    for (int k = 0; k < 16; k++) ibuf[k] = 8'h00;
    for (int k = 0; k < s.len(); k++) ibuf[k] = s[k];
  endtask

  task automatic run1(input string nm, input int len,
                      input int en, input int eo);
    int cyc;
    in_len = LW'(len);
    cs = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done"}, 32'(done), 1);
    chk({nm, "_ntok"}, 32'(ntok), en);
    chk({nm, "_ovf"}, 32'(ovf), eo);
    chk({nm, "_busy"}, 32'(busy), 0);
    repeat (2) @(negedge clk);
    chk({nm, "_hold"}, 32'(done), 1);
    cs = 1'b0;
    @(negedge clk);
    chk({nm, "_dclr"}, 32'(done), 0);
    chk({nm, "_q"}, q1.size(), 0);
  endtask

  initial begin
    int cyc;
    int ms0;
    n_chk    = 0;
    n_fail   = 0;
    m_starts = 0;
    rst_n    = 1'b0;
    cs       = 1'b0;
    cs2      = 1'b0;
    in_len   = '0;
    in_len2  = '0;
    m_done   = 1'b0;
    m_found  = 1'b0;
    m_len    = '0;
    clr_vocab();
    set_in("");
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ao", 32'(ao), 0);
    chk("rst_ntok", 32'(ntok), 0);
    chk("rst_mstart", 32'(m_start), 0);
    chk("rst_w", 32'(w), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_v(0, "ab");
    set_v(1, "a");
    set_v(2, "b");
    set_in("abb");
    push1(0, 0);
    push1(1, 2);
    run1("abb", 3, 2, 0);

    set_in("ab");
    push1(0, 1);
    run1("fit", 1, 1, 0);

    set_v(3, "cd");
    set_v(5, "cd");
    set_in("cd");
    push1(0, 3);
    run1("tie", 2, 1, 0);

    set_in("zz");
`ifdef ENCODER_SCHED_UNK_EN
    push1(0, 255);
    push1(1, 255);
    run1("unk", 2, 2, 0);
`else
    run1("unk", 2, 0, 0);
`endif

    ms0 = m_starts;
    in_len = '0;
    cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("len0_hold", 32'(done), 1);
    chk("len0_nstart", m_starts - ms0, 0);
    cs = 1'b0;
    @(negedge clk);
    chk("len0_clr", 32'(done), 0);

    set_in("abb");
    push1(0, 0);
    in_len = LW'(3);
    cs = 1'b1;
    cyc = 0;
    while (ntok !== LW'(1) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abt_to1", 32'(cyc < 1000), 1);
    cyc = 0;
    while (m_start !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abt_to2", 32'(cyc < 100), 1);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    chk("abt_busy", 32'(busy), 0);
    chk("abt_done", 32'(done), 0);
    chk("abt_ntok", 32'(ntok), 1);
    repeat (4) @(negedge clk);
    chk("abt_hold", 32'(ntok), 1);
    push1(0, 0);
    push1(1, 2);
    cs = 1'b1;
    @(negedge clk);
    chk("rst_ntok0", 32'(ntok), 0);
    chk("rst_ptr0", 32'(m_ai), 0);
    chk("rst_busy1", 32'(busy), 1);
    run1("rerun", 3, 2, 0);

    for (int i = 0; i < 4; i++) begin
      wr_t e;
      e.a = i;
      e.d = 0;
      q2.push_back(e);
    end
    in_len2 = 3'd6;
    cs2 = 1'b1;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("ovf_done", 32'(done2), 1);
    chk("ovf_flag", 32'(ovf2), 1);
    chk("ovf_ntok", 32'(ntok2), 4);
    chk("ovf_q", q2.size(), 0);
    cs2 = 1'b0;
    @(negedge clk);
    chk("ovf_dclr", 32'(done2), 0);

    set_in("abb");
    push1(0, 0);
    in_len = LW'(3);
    cs = 1'b1;
    cyc = 0;
    while (w !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("ar_to", 32'(cyc < 1000), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_w", 32'(w), 0);
    chk("ar_wdata", 32'(wdata), 0);
    chk("ar_ao", 32'(ao), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_ovf", 32'(ovf), 0);
    chk("ar_ntok", 32'(ntok), 0);
    chk("ar_mstart", 32'(m_start), 0);
    chk("ar_mai", 32'(m_ai), 0);
    chk("ar_mav", 32'(m_av), 0);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_q", q1.size(), 0);
    chk("ar_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
